spi_master_multi: RTL

- Parametrised SPI master, successor to the fixed 8-bit, two-slave SPI top.
- Supports configurable word width, slave count and SCLK divider, plus all four SPI modes (CPOL/CPHA) and MSB/LSB-first order, all selected per transfer.
- Drives one shared SCLK/MOSI/MISO bus and one active-low chip select per slave.
- Sits between a local controller (start/done handshake) and external or on-chip SPI slaves.

---
 rtl/spi_master_multi.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_multi.sv
// -----------------------------------------------------------------------------
// spi_master_multi
//   Parametrised SPI master with one shared SCLK/MOSI/MISO bus and one
//   active-low chip select per slave. Mode (CPOL/CPHA), bit order and target
//   slave are chosen per transfer and latched when start is accepted.
//
// Ports
//   clk, rst        system clock (rising edge), asynchronous active-low reset
//   start           one-cycle transfer request (ignored while busy or in the
//                   done cycle)
//   slave_sel       target slave index; out-of-range runs a bus cycle with no
//                   chip select and flags sel_err
//   tx_data         word to transmit
//   cpol/cpha       SPI mode for this transfer
//   lsb_first       bit order for both directions
//   busy            transfer in progress
//   done            one-cycle completion pulse; rx_data valid from this cycle
//   sel_err         pulses with done when slave_sel >= NUM_SLAVES
//   rx_data         last received word
//   sclk/mosi/miso  SPI bus
//   cs_n            active-low chip selects
//
// Sequence: IDLE -> SETUP (CLK_DIV) -> XFER (2*DATA_WIDTH half-periods of
// CLK_DIV) -> HOLD (CLK_DIV) -> DONE (1, cs_n released) -> IDLE. All outputs
// are registered; done/rx_data/sel_err are loaded on the edge leaving DONE,
// so the done pulse appears CLK_DIV*(2*DATA_WIDTH+2)+1 edges after the edge
// that sampled start.
// -----------------------------------------------------------------------------
module spi_master_multi #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 2,
    parameter int CLK_DIV    = 2,
    parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SEL_W-1:0]      slave_sel,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    output logic                  busy,
    output logic                  done,
    output logic                  sel_err,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] cs_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TGL_W = $clog2(2 * DATA_WIDTH) + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TGL_W-1:0] TGL_LAST = TGL_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [TGL_W-1:0]        tgl_q, tgl_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    cpol_q, cpol_d;
    logic                    cpha_q, cpha_d;
    logic                    lsb_q, lsb_d;
    logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic [NUM_SLAVES-1:0]   cs_n_q, cs_n_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    sel_err_q, sel_err_d;

    logic                    half_end;
    logic                    sel_oor;
    logic [BIT_W-1:0]        cur_bit;   // bit number of the current SCLK cycle
    logic [BIT_W-1:0]        nxt_bit;   // bit number presented after a trailing edge

    // Physical bit position of the n-th transmitted/received bit.
    function automatic logic [BIT_W-1:0] bit_idx(input logic [BIT_W-1:0] n,
                                                 input logic             lsb);
        return lsb ? n : (BIT_W'(DATA_WIDTH - 1) - n);
    endfunction

    assign half_end = (div_q == DIV_LAST);
    assign sel_oor  = (32'(sel_q) >= 32'(NUM_SLAVES));
    assign cur_bit  = BIT_W'(tgl_q >> 1);
    assign nxt_bit  = BIT_W'((tgl_q + TGL_W'(1)) >> 1);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        tgl_d     = tgl_q;
        tx_d      = tx_q;
        sel_d     = sel_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        sel_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                div_d  = '0;
                tgl_d  = '0;
                // done_q marks the done cycle: a start seen there is dropped.
                if (start && !done_q) begin
                    tx_d    = tx_data;
                    sel_d   = slave_sel;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    rx_sh_d = '0;
                    state_d = S_SETUP;
                    if (!cpha) mosi_d = tx_data[bit_idx('0, lsb_first)];
                end
            end

            S_SETUP: begin
                div_d = div_q + DIV_W'(1);
                if (half_end) begin
                    div_d   = '0;
                    state_d = S_XFER;
                end
            end

            S_XFER: begin
                div_d = div_q + DIV_W'(1);
                if (half_end) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    tgl_d  = tgl_q + TGL_W'(1);
                    if (!tgl_q[0]) begin
                        // leading edge
                        if (cpha_q) mosi_d = tx_q[bit_idx(cur_bit, lsb_q)];
                        else        rx_sh_d[bit_idx(cur_bit, lsb_q)] = miso;
                    end else begin
                        // trailing edge; the last one leaves mosi on the final bit
                        if (cpha_q)                 rx_sh_d[bit_idx(cur_bit, lsb_q)] = miso;
                        else if (tgl_q != TGL_LAST) mosi_d = tx_q[bit_idx(nxt_bit, lsb_q)];
                        if (tgl_q == TGL_LAST) begin
                            tgl_d   = '0;
                            state_d = S_HOLD;
                        end
                    end
                end
            end

            S_HOLD: begin
                div_d = div_q + DIV_W'(1);
                if (half_end) begin
                    div_d   = '0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d   = S_IDLE;
                mosi_d    = 1'b0;
                sclk_d    = cpol_q;
                done_d    = 1'b1;
                sel_err_d = sel_oor;
                rx_data_d = rx_sh_q;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);

        // Chip select from the next state so cs_n falls with the start edge and
        // rises on entry to DONE. An out-of-range index matches no bit.
        cs_n_d = '1;
        if (state_d == S_SETUP || state_d == S_XFER || state_d == S_HOLD) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                cs_n_d[i] = (32'(sel_d) != i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            tgl_q     <= '0;
            tx_q      <= '0;
            sel_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tgl_q     <= tgl_d;
            tx_q      <= tx_d;
            sel_q     <= sel_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sel_err = sel_err_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule
